// File: rtl/conv_frame_loader.sv
// Sliding-window frame loader feeding the Conv block: captures channel-interleaved
// samples, snapshots the window every STRIDE timesteps and pulses Conv's start.
module conv_frame_loader #(
    parameter int DATA_W      = 16,
    parameter int N_CH        = 4,
    parameter int N_T         = 10,
    parameter int STRIDE      = 5,
    parameter int CONV_CYCLES = 20
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_clear,
    input  logic                       i_valid,
    input  logic [DATA_W-1:0]          i_sample,
    output logic                       o_ready,
    output logic [N_CH*N_T*DATA_W-1:0] o_data,
    output logic                       o_start,
    output logic                       o_busy
);
    localparam int N_WIN  = N_CH * N_T;
    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int FILL_W = $clog2(N_T + 1);
    localparam int STR_W  = $clog2(STRIDE + 1);
    localparam int RUN_W  = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    logic [DATA_W-1:0] win_q [N_WIN];
    logic [DATA_W-1:0] win_d [N_WIN];
    logic [DATA_W-1:0] stg_q [N_CH];
    logic [DATA_W-1:0] stg_d [N_CH];
    logic [CH_W-1:0]   ch_cnt_q, ch_cnt_d;
    logic [FILL_W-1:0] fill_cnt_q, fill_cnt_d;
    logic [STR_W-1:0]  stride_cnt_q, stride_cnt_d;
    logic              pending_q, pending_d;

    state_t                     state_q;
    logic [RUN_W-1:0]           run_cnt_q;
    logic                       start_q;
    logic                       busy_q;
    logic [N_CH*N_T*DATA_W-1:0] frame_q;

    logic accept;
    logic last_ch;
    logic launch;

    assign accept  = i_valid && !pending_q && !i_clear;
    assign last_ch = (ch_cnt_q == CH_W'(N_CH - 1));
    assign launch  = (state_q == S_IDLE) && pending_q && !i_clear;

    assign o_ready = !pending_q;
    assign o_data  = frame_q;
    assign o_start = start_q;
    assign o_busy  = busy_q;

    always_comb begin
        win_d        = win_q;
        stg_d        = stg_q;
        ch_cnt_d     = ch_cnt_q;
        fill_cnt_d   = fill_cnt_q;
        stride_cnt_d = stride_cnt_q;
        pending_d    = pending_q;
        if (i_clear) begin
            ch_cnt_d     = '0;
            fill_cnt_d   = '0;
            stride_cnt_d = '0;
            pending_d    = 1'b0;
        end else begin
            if (launch)
                pending_d = 1'b0;
            if (accept) begin
                stg_d[ch_cnt_q] = i_sample;
                if (!last_ch) begin
                    ch_cnt_d = ch_cnt_q + 1'b1;
                end else begin
                    ch_cnt_d = '0;
                    // the last channel goes straight from the input via stg_d
                    for (int c = 0; c < N_CH; c++) begin
                        for (int t = 0; t < N_T - 1; t++)
                            win_d[c*N_T+t] = win_q[c*N_T+t+1];
                        win_d[c*N_T+N_T-1] = stg_d[c];
                    end
                    if (fill_cnt_q != FILL_W'(N_T)) begin
                        fill_cnt_d = fill_cnt_q + 1'b1;
                        if (fill_cnt_d == FILL_W'(N_T))
                            pending_d = 1'b1;
                    end else if (stride_cnt_q == STR_W'(STRIDE - 1)) begin
                        stride_cnt_d = '0;
                        pending_d    = 1'b1;
                    end else begin
                        stride_cnt_d = stride_cnt_q + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < N_WIN; i++)
                win_q[i] <= '0;
            for (int i = 0; i < N_CH; i++)
                stg_q[i] <= '0;
            ch_cnt_q     <= '0;
            fill_cnt_q   <= '0;
            stride_cnt_q <= '0;
            pending_q    <= 1'b0;
        end else begin
            win_q        <= win_d;
            stg_q        <= stg_d;
            ch_cnt_q     <= ch_cnt_d;
            fill_cnt_q   <= fill_cnt_d;
            stride_cnt_q <= stride_cnt_d;
            pending_q    <= pending_d;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            run_cnt_q <= '0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            frame_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (launch) begin
                        for (int i = 0; i < N_WIN; i++)
                            frame_q[i*DATA_W +: DATA_W] <= win_q[i];
                        start_q   <= 1'b1;
                        busy_q    <= 1'b1;
                        run_cnt_q <= '0;
                        state_q   <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (run_cnt_q == RUN_W'(CONV_CYCLES - 1)) begin
                        start_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        run_cnt_q <= run_cnt_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_frame_loader.sv
// Directed bench for conv_frame_loader: default instance plus a STRIDE=1
// instance used for the backpressure scenario.
module tb_conv_frame_loader;
    localparam int DW  = 16;
    localparam int NCH = 4;
    localparam int NT  = 10;
    localparam int FW  = NCH * NT * DW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          clr, vld, rdy, st, bsy;
    logic [DW-1:0] smp;
    logic [FW-1:0] dat;
    logic          b_clr, b_vld, b_rdy, b_st, b_bsy;
    logic [DW-1:0] b_smp;
    logic [FW-1:0] b_dat;

    conv_frame_loader u_dut (
        .i_clk(clk), .i_rst(rst), .i_clear(clr), .i_valid(vld),
        .i_sample(smp), .o_ready(rdy), .o_data(dat),
        .o_start(st), .o_busy(bsy)
    );

    conv_frame_loader #(.STRIDE(1)) u_bp (
        .i_clk(clk), .i_rst(rst), .i_clear(b_clr), .i_valid(b_vld),
        .i_sample(b_smp), .o_ready(b_rdy), .o_data(b_dat),
        .o_start(b_st), .o_busy(b_bsy)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // run tracker for the default instance
    logic          prev_st = 1'b0;
    logic [FW-1:0] prev_dat;
    int launches = 0, rise_cyc = 0, fall_cyc = 0, run_len = 0;
    int runs_done = 0, stable_err = 0;
    int run_log [64];
    always @(negedge clk) begin
        if (st && !prev_st) begin
            launches++;
            rise_cyc = cyc;
            run_len  = 1;
        end else if (st) begin
            run_len++;
            if (dat !== prev_dat) stable_err++;
        end else if (prev_st) begin
            fall_cyc = cyc;
            run_log[runs_done % 64] = run_len;
            runs_done++;
        end
        prev_st  = st;
        prev_dat = dat;
    end

    // frame capture for the STRIDE=1 instance
    logic          b_prev = 1'b0;
    bit            b_stall = 1'b0;
    int            b_launch = 0, b_acc = 0;
    logic [FW-1:0] b_frames [16];
    always @(negedge clk) begin
        if (b_st && !b_prev) begin
            if (b_launch < 16) b_frames[b_launch] = b_dat;
            b_launch++;
        end
        b_prev = b_st;
        if (b_bsy && !b_rdy) b_stall = 1'b1;
    end
    always @(posedge clk)
        if (!rst && b_vld && b_rdy && !b_clr) b_acc++;

    function automatic logic [FW-1:0] exp_frame(input logic [15:0] base,
                                                 input bit neg, input int t0);
        logic [FW-1:0] f;
        logic [15:0]   k;
        f = '0;
        for (int c = 0; c < NCH; c++)
            for (int t = 0; t < NT; t++) begin
                k = 16'(4 * (t + t0) + c);
                f[(c*NT+t)*DW +: DW] = neg ? base - k : base + k;
            end
        return f;
    endfunction

    task automatic feed(input logic [15:0] v, input bit gap, output bit stalled);
        int  n;
        bit  ok;
        n = 0;
        stalled = 1'b0;
        vld = 1'b1;
        smp = v;
        forever begin
            ok = rdy;
            @(posedge clk);
            #1;
            if (ok) break;
            stalled = 1'b1;
            n++;
            if (n > 200) begin
                checks++; errors++;
                $display("FAIL feed_timeout: sample %h not accepted in 200 cycles", v);
                break;
            end
        end
        last_acc = cyc;
        vld = 1'b0;
        if (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic b_feed(input logic [15:0] v);
        int n;
        bit ok;
        n = 0;
        b_vld = 1'b1;
        b_smp = v;
        forever begin
            ok = b_rdy;
            @(posedge clk);
            #1;
            if (ok) break;
            n++;
            if (n > 200) begin
                checks++; errors++;
                $display("FAIL bp_feed_timeout: sample %h not accepted", v);
                break;
            end
        end
        b_vld = 1'b0;
    endtask

    task automatic wait_launch(input int prev);
        int n;
        n = 0;
        while (launches <= prev) begin
            @(negedge clk);
            #1;
            n++;
            if (n > 300) begin
                checks++; errors++;
                $display("FAIL launch_timeout: launches %0d required > %0d", launches, prev);
                break;
            end
        end
    endtask

    task automatic wait_run_end(input int prev);
        int n;
        n = 0;
        while (runs_done <= prev) begin
            @(negedge clk);
            #1;
            n++;
            if (n > 300) begin
                checks++; errors++;
                $display("FAIL run_end_timeout: runs %0d required > %0d", runs_done, prev);
                break;
            end
        end
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks += 6;
        if (st !== 1'b0) begin errors++; $display("FAIL rst_start got %b exp 0", st); end
        if (bsy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", bsy); end
        if (rdy !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", rdy); end
        if (dat !== '0) begin errors++; $display("FAIL rst_data got %h exp 0", dat); end
        if (b_rdy !== 1'b1) begin errors++; $display("FAIL rst_bp_ready got %b exp 1", b_rdy); end
        if (b_st !== 1'b0) begin errors++; $display("FAIL rst_bp_start got %b exp 0", b_st); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fill();
        int s, prev;
        bit stl, any;
        logic [FW-1:0] e;
        s = cyc;
        prev = launches;
        any = 1'b0;
        for (int k = 0; k < 40; k++) begin
            feed(16'h0100 + 16'(k), 1'b0, stl);
            any |= stl;
        end
        wait_launch(prev);
        e = exp_frame(16'h0100, 1'b0, 0);
        checks += 5;
        if (rise_cyc !== last_acc + 1) begin
            errors++; $display("FAIL fill_latency got %0d exp %0d", rise_cyc, last_acc + 1);
        end
        if (rise_cyc - s !== 41) begin
            errors++; $display("FAIL fill_launch_cycle got %0d exp 41", rise_cyc - s);
        end
        if (dat !== e) begin errors++; $display("FAIL fill_data got %h exp %h", dat, e); end
        if (any) begin errors++; $display("FAIL fill_ready got stall exp none"); end
        if (bsy !== 1'b1) begin errors++; $display("FAIL fill_busy got %b exp 1", bsy); end
    endtask

    task automatic test_stride();
        int prev, r;
        bit stl;
        logic [FW-1:0] e;
        prev = launches;
        for (int k = 40; k < 60; k++) feed(16'h0100 + 16'(k), 1'b0, stl);
        wait_launch(prev);
        e = exp_frame(16'h0100, 1'b0, 5);
        checks += 4;
        if (rise_cyc - fall_cyc !== 1) begin
            errors++; $display("FAIL stride_gap got %0d exp 1", rise_cyc - fall_cyc);
        end
        if (run_log[(runs_done - 1) % 64] !== 20) begin
            errors++; $display("FAIL run1_len got %0d exp 20", run_log[(runs_done - 1) % 64]);
        end
        if (dat !== e) begin errors++; $display("FAIL stride_data got %h exp %h", dat, e); end
        if (stable_err !== 0) begin
            errors++; $display("FAIL frame_stable got %0d changes exp 0", stable_err);
        end
        r = runs_done;
        wait_run_end(r);
        checks += 2;
        if (run_log[r % 64] !== 20) begin
            errors++; $display("FAIL run2_len got %0d exp 20", run_log[r % 64]);
        end
        if (dat !== e) begin errors++; $display("FAIL stride_hold got %h exp %h", dat, e); end
    endtask

    task automatic test_reset_mid_run();
        int prev;
        bit stl;
        logic [FW-1:0] e;
        prev = launches;
        for (int k = 0; k < 40; k++) feed(16'h0200 + 16'(k), 1'b0, stl);
        wait_launch(prev);
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks += 4;
        if (st !== 1'b0) begin errors++; $display("FAIL rmid_start got %b exp 0", st); end
        if (bsy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b exp 0", bsy); end
        if (dat !== '0) begin errors++; $display("FAIL rmid_data got %h exp 0", dat); end
        if (rdy !== 1'b1) begin errors++; $display("FAIL rmid_ready got %b exp 1", rdy); end
        @(posedge clk);
        #1 rst = 1'b0;
        prev = launches;
        for (int k = 0; k < 39; k++) feed(16'h0300 + 16'(k), 1'b0, stl);
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (launches !== prev || st !== 1'b0) begin
            errors++; $display("FAIL rmid_early got launches %0d start %b exp %0d 0", launches, st, prev);
        end
        feed(16'h0300 + 16'd39, 1'b0, stl);
        wait_launch(prev);
        e = exp_frame(16'h0300, 1'b0, 0);
        checks += 2;
        if (rise_cyc !== last_acc + 1) begin
            errors++; $display("FAIL rmid_latency got %0d exp %0d", rise_cyc, last_acc + 1);
        end
        if (dat !== e) begin errors++; $display("FAIL rmid_data2 got %h exp %h", dat, e); end
    endtask

    task automatic test_clear();
        int prev, r0;
        bit stl;
        logic [FW-1:0] e_old, e_new;
        reset_pulse();
        for (int k = 0; k < 42; k++) feed(16'hff0c - 16'(k), 1'b0, stl);
        checks++;
        if (st !== 1'b1) begin errors++; $display("FAIL clr_run_active got %b exp 1", st); end
        r0 = runs_done;
        clr = 1'b1;
        vld = 1'b1;
        smp = 16'h7fff;
        @(posedge clk);
        #1;
        clr = 1'b0;
        vld = 1'b0;
        prev = launches;
        for (int k = 0; k < 40; k++) feed(16'hff0c - 16'd100 - 16'(k), 1'b0, stl);
        e_old = exp_frame(16'hff0c, 1'b1, 0);
        e_new = exp_frame(16'hff0c - 16'd100, 1'b1, 0);
        checks += 2;
        if (runs_done <= r0 || run_log[r0 % 64] !== 20) begin
            errors++; $display("FAIL clr_run_len got %0d exp 20", run_log[r0 % 64]);
        end
        if (dat !== e_old) begin errors++; $display("FAIL clr_hold got %h exp %h", dat, e_old); end
        wait_launch(prev);
        checks++;
        if (dat !== e_new) begin errors++; $display("FAIL clr_data got %h exp %h", dat, e_new); end
    endtask

    task automatic test_valid_gaps();
        int s, prev;
        bit stl;
        logic [FW-1:0] e;
        reset_pulse();
        s = cyc;
        prev = launches;
        for (int k = 0; k < 40; k++) feed(16'h0100 + 16'(k), 1'b1, stl);
        wait_launch(prev);
        e = exp_frame(16'h0100, 1'b0, 0);
        checks += 2;
        if (rise_cyc - s !== 80) begin
            errors++; $display("FAIL gap_launch_cycle got %0d exp 80", rise_cyc - s);
        end
        if (dat !== e) begin errors++; $display("FAIL gap_data got %h exp %h", dat, e); end
    endtask

    task automatic test_back_to_back();
        int n;
        logic [FW-1:0] e;
        for (int k = 0; k < 80; k++) b_feed(16'h0100 + 16'(k));
        n = 0;
        while (b_launch < 11 && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        repeat (30) @(posedge clk);
        #1;
        checks += 3;
        if (b_launch !== 11) begin errors++; $display("FAIL bp_launches got %0d exp 11", b_launch); end
        if (b_acc !== 80) begin errors++; $display("FAIL bp_accepted got %0d exp 80", b_acc); end
        if (!b_stall) begin errors++; $display("FAIL bp_ready_drop got none exp stall"); end
        for (int j = 0; j < 11; j++) begin
            e = exp_frame(16'h0100, 1'b0, j);
            checks++;
            if (b_frames[j] !== e) begin
                errors++; $display("FAIL bp_frame%0d got %h exp %h", j, b_frames[j], e);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        clr = 1'b0; vld = 1'b0; smp = '0;
        b_clr = 1'b0; b_vld = 1'b0; b_smp = '0;
        test_reset();
        test_fill();
        test_stride();
        test_reset_mid_run();
        test_clear();
        test_valid_gaps();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/conv_frame_loader.md
Name: conv_frame_loader

Overview:
- Front-end producer for the Conv block.
- Accepts a channel-interleaved stream of normalised Q8.8 sensor samples, one 16-bit sample per handshake.
- Keeps a sliding window of N_T timesteps per channel and, every STRIDE timesteps once the window is full, snapshots it into the flat frame Conv consumes on i_data.
- Holds Conv's i_start high for CONV_CYCLES cycles while the snapshot stays frozen.

Parameters:
DATA_W, 16, sample width (signed Q8.8)
N_CH, 4, sensor channels per timestep
N_T, 10, timesteps per window
STRIDE, 5, timesteps between consecutive launches once the window is full (1..N_T)
CONV_CYCLES, 20, cycles o_start is held per launch

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  asynchronous, active-high reset
i_clear  in  1  synchronous window flush
i_valid  in  1  sample valid
i_sample  in  DATA_W  signed sample; channel order 0..N_CH-1 within each timestep
o_ready  out  1  sample accepted on an edge where i_valid && o_ready
o_data  out  N_CH*N_T x DATA_W  frame, entry [ch*N_T+t]; t=0 oldest, t=N_T-1 newest; drives Conv i_data
o_start  out  1  drives Conv i_start
o_busy  out  1  high while the FSM is in RUN

Behaviour:
- Reset (async, immediate): window and staging registers, o_data entries = 0; o_start=0; o_busy=0; o_ready=1; ch_cnt=0; fill_cnt=0; stride_cnt=0; pending=0; state=IDLE. Reset mid-RUN drops o_start in the same cycle.
- Channel capture:
  - Accepted sample is written to staging[ch_cnt]; ch_cnt increments.
  - When ch_cnt==N_CH-1 is accepted, the timestep completes: every channel row shifts toward t=0; the staging row plus the current sample enter at t=N_T-1; ch_cnt wraps to 0.
- Counters:
  - fill_cnt saturates at N_T.
  - On a completion with fill_cnt already N_T, stride_cnt increments.
- Pending:
  - Set by the completion that makes fill_cnt reach N_T.
  - Also set by a completion that makes stride_cnt+1==STRIDE; stride_cnt clears at that point.
- Stall: o_ready = !pending. At most one frame is ever pending; no sample is dropped.
- FSM:
  - IDLE: if pending, load o_data from the window on the next edge, set o_start=1, o_busy=1, clear pending, run_cnt=0, go to RUN.
  - RUN: run_cnt increments each cycle. When run_cnt==CONV_CYCLES-1, clear o_start and o_busy and go to IDLE, so o_start is high for exactly CONV_CYCLES cycles.
  - A pending frame raised during RUN waits; it launches on the edge after the return to IDLE, so there is one idle cycle with o_start=0 between runs.
- Latency: the edge accepting the launching sample sets pending. In IDLE, o_data and o_start update on the following edge.
- Frame stability: o_data changes only at launch. It is held through RUN and afterwards until the next launch.
- Input during RUN: accepted while pending=0; the window keeps shifting independently of o_data.
- i_clear:
  - Clears ch_cnt, fill_cnt, stride_cnt and pending.
  - Does not abort RUN and does not alter o_data.
  - Window contents are don't-care until refilled.
  - i_clear together with a valid sample: clear wins and the sample is discarded.
- Arithmetic: pure data movement; samples are stored bit-exact, sign preserved.

Test Plan:
- Fill (defaults):
  - Stimulus: 40 samples, value 16'h0100+k for arrival index k, i_valid continuous.
  - Response: o_start rises the edge after sample 40 is accepted and stays high exactly 20 cycles; o_data[ch*10+t] = 16'h0100+4t+ch; o_ready stays 1.
- Stride:
  - Stimulus: 20 further samples (k=40..59), continuous.
  - Response: second launch one cycle after the first RUN ends; o_data[ch*10+t] = 16'h0100+4(t+5)+ch; o_data frozen during each RUN.
- Backpressure (STRIDE=1):
  - Stimulus: continuous valid for 80 samples.
  - Response: o_ready deasserts while a frame is pending during RUN. Every launch shows consecutive timesteps with no gaps or duplicates, and total accepted equals 80.
- Reset mid-RUN:
  - Stimulus: assert i_rst 10 cycles into RUN.
  - Response: o_start=0 and o_busy=0 immediately, o_data all 0, o_ready=1. The next launch needs 40 new samples.
- Clear and alignment:
  - Stimulus: feed 42 samples (negative values, e.g. -16'h00f4), pulse i_clear, then feed 40 samples.
  - Response: the launch after the clear shows correct channel alignment (ch0 at index 0) and exact sign-preserved values.
  - Response: a RUN already active when i_clear pulses completes its 20 cycles.
- Valid gaps:
  - Stimulus: i_valid toggled 1/0 every cycle.
  - Response: same frames as the Fill case, with the launch delayed proportionally.
